amba3_apb_regfile: RTL and testbench

AMBA3_APB_REGFILE -- requirements
Module: amba3_apb_regfile

---
 rtl/amba3_apb_regfile_if.sv | 30 +++
 rtl/amba3_apb_regfile.sv | 100 ++++++++++
 tb/tb_amba3_apb_regfile.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/amba3_apb_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : amba3_apb_regfile_if
// Brief    : AMBA3 APB bus bundle (request and response) for the register file
// Revision : 1.0 - initial release
// ============================================================================
interface amba3_apb_regfile_if #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
);
    logic [ADDR_BITS-1:0] paddr;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [DATA_BITS-1:0] pwdata;
    logic                 pready;
    logic [DATA_BITS-1:0] prdata;
    logic                 pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, prdata, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/amba3_apb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : amba3_apb_regfile
// Brief    : APB3 slave with NUM_REGS word registers and programmable wait states
// Revision : 1.0 - initial release
// ============================================================================
module amba3_apb_regfile #(
    parameter int ADDR_BITS   = 32,
    parameter int DATA_BITS   = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0
) (
    input  wire logic           pclk,
    input  wire logic           preset,
    amba3_apb_regfile_if.slave  apb
);

    localparam int         c_IDX_BITS = $clog2(NUM_REGS);
    localparam logic [3:0] c_WAIT     = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_wait;
    logic [ADDR_BITS-1:0]   r_addr;
    logic                   r_write;
    logic [DATA_BITS-1:0]   r_wdata;
    logic [DATA_BITS-1:0]   r_regs [NUM_REGS];

    logic [c_IDX_BITS-1:0]  w_idx;
    logic                   w_err;
    logic                   w_done;

    // Decode works on the address captured at setup, never on live paddr.
    assign w_idx  = r_addr[c_IDX_BITS+1:2];
    assign w_err  = (r_addr[1:0] != 2'b00) || (|(r_addr >> (c_IDX_BITS + 2)));
    assign w_done = (r_state == S_ACCESS) && (r_wait == 4'd0) &&
                    apb.psel && apb.penable;

    assign apb.pready  = w_done;
    assign apb.pslverr = w_done && w_err;
    assign apb.prdata  = (w_done && !r_write && !w_err) ? r_regs[w_idx] : '0;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= S_IDLE;
            r_wait  <= 4'd0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (apb.psel && !apb.penable) begin
                        r_addr  <= apb.paddr;
                        r_write <= apb.pwrite;
                        r_wdata <= apb.pwdata;
                        r_wait  <= c_WAIT;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!apb.psel) begin
                        // Master walked away mid-transfer: drop it silently.
                        r_wait  <= 4'd0;
                        r_state <= S_HOLD;
                    end else if (r_wait != 4'd0) begin
                        r_wait <= r_wait - 4'd1;
                    end else if (w_done) begin
                        r_state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (!apb.psel || !apb.penable) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_done && r_write && !w_err) begin
            r_regs[w_idx] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_amba3_apb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_amba3_apb_regfile
// Brief    : Directed self-checking bench; three DUTs with 0, 3 and 2 wait states
// Revision : 1.0 - initial release
// ============================================================================
module tb_amba3_apb_regfile;

    localparam int c_AW = 32;
    localparam int c_DW = 32;

    logic            pclk = 1'b0;
    logic            preset;
    logic [c_AW-1:0] paddr;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [c_DW-1:0] pwdata;
    int              sel;

    logic            obs_pready;
    logic [c_DW-1:0] obs_prdata;
    logic            obs_pslverr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 pclk = ~pclk;

    amba3_apb_regfile_if #(.ADDR_BITS(c_AW), .DATA_BITS(c_DW)) if0 ();
    amba3_apb_regfile_if #(.ADDR_BITS(c_AW), .DATA_BITS(c_DW)) if3 ();
    amba3_apb_regfile_if #(.ADDR_BITS(c_AW), .DATA_BITS(c_DW)) if2 ();

    // Shared request lines; only the selected DUT sees psel.
    assign if0.paddr = paddr;  assign if0.penable = penable;
    assign if0.pwrite = pwrite; assign if0.pwdata = pwdata;
    assign if0.psel = psel && (sel == 0);
    assign if3.paddr = paddr;  assign if3.penable = penable;
    assign if3.pwrite = pwrite; assign if3.pwdata = pwdata;
    assign if3.psel = psel && (sel == 1);
    assign if2.paddr = paddr;  assign if2.penable = penable;
    assign if2.pwrite = pwrite; assign if2.pwdata = pwdata;
    assign if2.psel = psel && (sel == 2);

    amba3_apb_regfile #(.ADDR_BITS(c_AW), .DATA_BITS(c_DW), .NUM_REGS(16), .WAIT_STATES(0))
        u_dut0 (.pclk(pclk), .preset(preset), .apb(if0));
    amba3_apb_regfile #(.ADDR_BITS(c_AW), .DATA_BITS(c_DW), .NUM_REGS(16), .WAIT_STATES(3))
        u_dut3 (.pclk(pclk), .preset(preset), .apb(if3));
    amba3_apb_regfile #(.ADDR_BITS(c_AW), .DATA_BITS(c_DW), .NUM_REGS(16), .WAIT_STATES(2))
        u_dut2 (.pclk(pclk), .preset(preset), .apb(if2));

    always_comb begin
        obs_pready  = if0.pready;
        obs_prdata  = if0.prdata;
        obs_pslverr = if0.pslverr;
        case (sel)
            1: begin
                obs_pready  = if3.pready;
                obs_prdata  = if3.prdata;
                obs_pslverr = if3.pslverr;
            end
            2: begin
                obs_pready  = if2.pready;
                obs_prdata  = if2.prdata;
                obs_pslverr = if2.pslverr;
            end
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic apb_setup(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d);
        sel     = k;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
    endtask

    // Access phase; returns right after sampling the completing cycle so the
    // next setup lands on the completion edge (back-to-back).
    task automatic apb_access(output logic [31:0] rd, output logic er, output int waits);
        logic done;
        done  = 1'b0;
        rd    = '0;
        er    = 1'b0;
        waits = 0;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge pclk);
            if (obs_pready) begin
                rd   = obs_prdata;
                er   = obs_pslverr;
                done = 1'b1;
            end else begin
                check_eq("wait_prdata", obs_prdata, 32'h0);
                check_eq("wait_pslverr", {31'h0, obs_pslverr}, 32'h0);
                waits++;
                @(posedge pclk); #1;
            end
        end
        check_eq("xfer_done", {31'h0, done}, 32'h1);
    endtask

    task automatic apb_xfer(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic er, output int waits);
        @(posedge pclk); #1;
        apb_setup(k, wr, a, d);
        apb_access(rd, er, waits);
    endtask

    task automatic write_chk(input int k, input logic [31:0] a, input logic [31:0] d,
                             input logic exp_err, input int exp_waits, input string tag);
        logic [31:0] rd; logic er; int w;
        apb_xfer(k, 1'b1, a, d, rd, er, w);
        check_eq({tag, "_err"}, {31'h0, er}, {31'h0, exp_err});
        check_eq({tag, "_waits"}, w, exp_waits);
        check_eq({tag, "_prdata"}, rd, 32'h0);
    endtask

    task automatic read_chk(input int k, input logic [31:0] a, input logic [31:0] exp_d,
                            input logic exp_err, input int exp_waits, input string tag);
        logic [31:0] rd; logic er; int w;
        apb_xfer(k, 1'b0, a, 32'h0, rd, er, w);
        check_eq({tag, "_data"}, rd, exp_d);
        check_eq({tag, "_err"}, {31'h0, er}, {31'h0, exp_err});
        check_eq({tag, "_waits"}, w, exp_waits);
    endtask

    task automatic bus_idle(input int n);
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        repeat (n - 1) @(posedge pclk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] rd; logic er; int w;
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; sel = 0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check_eq("rst_pready0",  {31'h0, if0.pready},  32'h0);
        check_eq("rst_prdata0",  if0.prdata,           32'h0);
        check_eq("rst_pslverr0", {31'h0, if0.pslverr}, 32'h0);
        check_eq("rst_pready3",  {31'h0, if3.pready},  32'h0);
        check_eq("rst_pready2",  {31'h0, if2.pready},  32'h0);
        preset = 1'b0;

        // Zero wait states: write then read back.
        write_chk(0, 32'h08, 32'hDEADBEEF, 1'b0, 0, "w08");
        read_chk (0, 32'h08, 32'hDEADBEEF, 1'b0, 0, "r08");

        // Three wait states: fresh read, then write/read round trip.
        read_chk (1, 32'h04, 32'h0,        1'b0, 3, "ws3_r04");
        write_chk(1, 32'h04, 32'hCAFE0001, 1'b0, 3, "ws3_w04");
        read_chk (1, 32'h04, 32'hCAFE0001, 1'b0, 3, "ws3_r04b");

        // Out-of-range and misaligned accesses error out without side effects.
        write_chk(0, 32'h40, 32'h12345678, 1'b1, 0, "w40");
        write_chk(0, 32'h06, 32'h87654321, 1'b1, 0, "w06");
        read_chk (0, 32'h40, 32'h0,        1'b1, 0, "r40");
        read_chk (0, 32'h09, 32'h0,        1'b1, 0, "r09");
        for (int i = 0; i < 16; i++) begin
            read_chk(0, 32'(i * 4), (i == 2) ? 32'hDEADBEEF : 32'h0, 1'b0, 0, "scan");
        end
        bus_idle(1);

        // Back-to-back writes with no idle cycle between them.
        write_chk(0, 32'h00, 32'h1, 1'b0, 0, "b2b_w00");
        write_chk(0, 32'h04, 32'h2, 1'b0, 0, "b2b_w04");
        read_chk (0, 32'h00, 32'h1, 1'b0, 0, "b2b_r00");
        read_chk (0, 32'h04, 32'h2, 1'b0, 0, "b2b_r04");
        bus_idle(2);

        // psel+penable with no setup phase must be ignored.
        @(posedge pclk); #1;
        sel = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hBAD;
        repeat (3) begin
            @(negedge pclk);
            check_eq("ign_pready", {31'h0, obs_pready}, 32'h0);
        end
        bus_idle(1);
        read_chk(0, 32'h00, 32'h1, 1'b0, 0, "ign_r00");
        bus_idle(1);

        // Abort during a wait state (2 wait states), then a normal transfer.
        @(posedge pclk); #1;
        apb_setup(2, 1'b1, 32'h10, 32'hAA);
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check_eq("abort_pready", {31'h0, obs_pready}, 32'h0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (2) begin
            @(negedge pclk);
            check_eq("abort_idle_pready", {31'h0, obs_pready}, 32'h0);
        end
        read_chk (2, 32'h10, 32'h0,  1'b0, 2, "abort_r10");
        write_chk(2, 32'h10, 32'h77, 1'b0, 2, "abort_w10");
        read_chk (2, 32'h10, 32'h77, 1'b0, 2, "abort_r10b");
        bus_idle(2);

        // Reset asserted in the access phase of a write.
        @(posedge pclk); #1;
        apb_setup(0, 1'b1, 32'h0C, 32'h55);
        @(posedge pclk); #1;
        preset = 1'b1; penable = 1'b1;
        @(negedge pclk);
        check_eq("rstx_pready",  {31'h0, obs_pready},  32'h0);
        check_eq("rstx_prdata",  obs_prdata,           32'h0);
        check_eq("rstx_pslverr", {31'h0, obs_pslverr}, 32'h0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check_eq("rstx_hold_pready", {31'h0, obs_pready}, 32'h0);

        // Setup captured on the first edge after reset release.
        @(posedge pclk); #1;
        apb_setup(0, 1'b1, 32'h14, 32'h99);
        #2 preset = 1'b0;
        apb_access(rd, er, w);
        check_eq("post_rst_w14_err",   {31'h0, er}, 32'h0);
        check_eq("post_rst_w14_waits", w,           0);

        read_chk(0, 32'h0C, 32'h0,  1'b0, 0, "post_rst_r0c");
        read_chk(0, 32'h08, 32'h0,  1'b0, 0, "post_rst_r08");
        read_chk(0, 32'h14, 32'h99, 1'b0, 0, "post_rst_r14");
        read_chk(1, 32'h04, 32'h0,  1'b0, 3, "post_rst_ws3_r04");
        bus_idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
